// File: rtl/cordic_defs.sv
// Shared constants, state encoding and arctangent table for the CORDIC cores.
package cordic_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_QUAD   = 3'd2,
        ST_ITER   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Angles in Q16.16 degrees
    localparam logic signed [31:0] DEG_90  = 32'sh005A0000;
    localparam logic signed [31:0] DEG_180 = 32'sh00B40000;
    localparam logic signed [31:0] DEG_360 = 32'sh01680000;

    // Inverse CORDIC gain in Q2.30, preloaded into x so no post-scaling is needed
    localparam logic signed [31:0] K_INIT  = 32'sh26DD3B6A;

    localparam int ATAN_DEPTH = 30;

    // round(atan(2^-i) * 180/pi * 2^16); entries beyond 22 round to zero
    function automatic logic signed [31:0] atan_entry(input logic [4:0] idx);
        logic signed [31:0] val;
        case (idx)
            5'd0:    val = 32'sd2949120;
            5'd1:    val = 32'sd1740967;
            5'd2:    val = 32'sd919879;
            5'd3:    val = 32'sd466945;
            5'd4:    val = 32'sd234379;
            5'd5:    val = 32'sd117305;
            5'd6:    val = 32'sd58666;
            5'd7:    val = 32'sd29335;
            5'd8:    val = 32'sd14668;
            5'd9:    val = 32'sd7334;
            5'd10:   val = 32'sd3667;
            5'd11:   val = 32'sd1833;
            5'd12:   val = 32'sd917;
            5'd13:   val = 32'sd458;
            5'd14:   val = 32'sd229;
            5'd15:   val = 32'sd115;
            5'd16:   val = 32'sd57;
            5'd17:   val = 32'sd29;
            5'd18:   val = 32'sd14;
            5'd19:   val = 32'sd7;
            5'd20:   val = 32'sd4;
            5'd21:   val = 32'sd2;
            5'd22:   val = 32'sd1;
            default: val = 32'sd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, indexed by micro-rotation number.
module cordic_atan_rom
    import cordic_defs::*;
(
    input  logic [4:0]         idx,
    output logic signed [31:0] atan_val
);

    // Pure table lookup; kept as its own block so a vectoring core can reuse it
    always_comb begin
        atan_val = atan_entry(idx);
    end

endmodule

// File: rtl/cordic_sincos_core.sv
// Iterative rotation-mode CORDIC: sine or cosine of a Q16.16 degree angle.
// One micro-rotation per clock after range reduction into [-90, 90] degrees.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a start rising edge
// ST_REDUCE | fold z into [-180, 180) by one 360-degree step per cycle
// ST_QUAD   | fold z into [-90, 90], remember whether to negate, seed x/y
// ST_ITER   | one micro-rotation per cycle for ITERATIONS cycles
// ST_FINISH | select/negate result, round to Q16.16, pulse done
module cordic_sincos_core
    import cordic_defs::*;
#(
    parameter int ITERATIONS = 16,
    parameter int DATA_W     = 32,
    parameter int INT_FRAC   = 30
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              rst,
    input  logic [DATA_W-1:0] theta_deg,
    input  logic              mode,
    input  logic              start,
    output logic [DATA_W-1:0] result_out,
    output logic              done,
    output logic              busy
);

    localparam int                SHIFT  = INT_FRAC - 16;
    localparam logic signed [31:0] RND   = 32'sd1 <<< (SHIFT - 1);
    localparam logic [4:0]        I_LAST = 5'(ITERATIONS - 1);

    state_t             state;
    logic               start_q;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
    logic [4:0]         iter;
    logic               mode_r;
    logic               neg_r;

    logic signed [31:0] atan_val;
    logic signed [31:0] x_sh;
    logic signed [31:0] y_sh;
    logic signed [31:0] fin_v;
    logic signed [31:0] fin_rnd;
    logic               launch;
    logic               dir_pos;

    cordic_atan_rom u_atan_rom (
        .idx      (iter),
        .atan_val (atan_val)
    );

    assign launch  = start && !start_q && (state == ST_IDLE) && !rst;
    assign dir_pos = !z[31];
    assign x_sh    = x >>> iter;
    assign y_sh    = y >>> iter;

    // Final select, optional negation and round-half-up from Q2.30 to Q16.16
    always_comb begin
        fin_v = mode_r ? x : y;
        if (neg_r) begin
            fin_v = -fin_v;
        end
        fin_rnd = (fin_v + RND) >>> SHIFT;
    end

    // Edge-detect history keeps tracking start through soft reset and busy
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // Main sequencer; soft reset aborts exactly like the hard reset
    always_ff @(posedge aclk) begin
        if (!aresetn || rst) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            iter       <= '0;
            mode_r     <= 1'b0;
            neg_r      <= 1'b0;
            result_out <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        z      <= theta_deg;
                        mode_r <= mode;
                        busy   <= 1'b1;
                        state  <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (z >= DEG_180) begin
                        z <= z - DEG_360;
                    end else if (z < -DEG_180) begin
                        z <= z + DEG_360;
                    end else begin
                        state <= ST_QUAD;
                    end
                end
                ST_QUAD: begin
                    // Exactly +/-90 stays on the non-negated path
                    if (z > DEG_90) begin
                        z     <= z - DEG_180;
                        neg_r <= 1'b1;
                    end else if (z < -DEG_90) begin
                        z     <= z + DEG_180;
                        neg_r <= 1'b1;
                    end else begin
                        neg_r <= 1'b0;
                    end
                    x     <= K_INIT;
                    y     <= '0;
                    iter  <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    if (dir_pos) begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - atan_val;
                    end else begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + atan_val;
                    end
                    if (iter == I_LAST) begin
                        state <= ST_FINISH;
                    end else begin
                        iter <= iter + 5'd1;
                    end
                end
                ST_FINISH: begin
                    result_out <= fin_rnd[DATA_W-1:0];
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos_core.sv
// Scoreboard bench for cordic_sincos_core: expected results come from real
// sin/cos of the input angle; a negedge monitor checks every done pulse.
module tb_cordic_sincos_core;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] theta_deg = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic [31:0] result_out;
    logic        done;
    logic        busy;

    cordic_sincos_core dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .rst        (rst),
        .theta_deg  (theta_deg),
        .mode       (mode),
        .start      (start),
        .result_out (result_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int exp_val;
        int exp_cyc;
        int theta;
        bit md;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] deg(input int d);
        return 32'(d * 65536);
    endfunction

    function automatic int ref_val(input logic [31:0] th, input bit m);
        real d, r, v;
        d = $itor($signed(th)) / 65536.0;
        r = d * 3.14159265358979323846 / 180.0;
        v = m ? $cos(r) : $sin(r);
        return $rtoi($floor(v * 65536.0 + 0.5));
    endfunction

    // Base latency of 20 plus one cycle per full-turn adjustment
    function automatic int ref_lat(input logic [31:0] th);
        longint z;
        int n;
        z = longint'($signed(th));
        n = 0;
        while (z >= 180 * 65536) begin z -= 360 * 65536; n++; end
        while (z < -180 * 65536) begin z += 360 * 65536; n++; end
        return 20 + n;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge aclk) begin
        if (done) begin
            exp_t e;
            int   act;
            int   diff;
            check("done_expected", sb.size() > 0, sb.size(), 1);
            check("busy_clear_at_done", busy == 1'b0, int'(busy), 0);
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                act  = $signed(result_out);
                diff = act - e.exp_val;
                if (diff < 0) diff = -diff;
                check($sformatf("value th=%0d md=%0d", e.theta, e.md), diff <= 4, act, e.exp_val);
                check($sformatf("latency th=%0d", e.theta), cyc == e.exp_cyc, cyc, e.exp_cyc);
            end
        end
    end

    task automatic push_exp(input logic [31:0] th, input bit m, input int base);
        exp_t e;
        e.exp_val = ref_val(th, m);
        e.exp_cyc = base + ref_lat(th);
        e.theta   = $signed(th);
        e.md      = m;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 400) begin
            @(negedge aclk);
            k++;
        end
        check("drain_timeout", sb.size() == 0, sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge aclk);
    endtask

    task automatic launch_only(input logic [31:0] th, input bit m);
        @(posedge aclk); #1;
        theta_deg = th;
        mode      = m;
        start     = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] th, input bit m);
        launch_only(th, m);
        push_exp(th, m, cyc);
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        check("busy_after_launch", busy == 1'b1, int'(busy), 1);
        wait_drain();
    endtask

    initial begin
        // Reset with start already high: release must count as an edge
        theta_deg = deg(30);
        mode      = 1'b0;
        start     = 1'b1;
        repeat (3) @(negedge aclk);
        check("reset_result", result_out == 32'h0, int'(result_out), 0);
        check("reset_done", done == 1'b0, int'(done), 0);
        check("reset_busy", busy == 1'b0, int'(busy), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        push_exp(deg(30), 1'b0, cyc);
        @(posedge aclk); #1;
        start = 1'b0;
        wait_drain();

        // Directed angles, including quadrant folding and full-turn reduction
        run_op(deg(30), 1'b0);
        run_op(deg(60), 1'b1);
        run_op(deg(0), 1'b1);
        run_op(deg(90), 1'b0);
        run_op(deg(-90), 1'b0);
        run_op(deg(150), 1'b0);
        run_op(32'hFF880000, 1'b1);
        run_op(deg(180), 1'b1);
        run_op(deg(180), 1'b0);
        run_op(deg(390), 1'b0);
        run_op(32'h80000000, 1'b0);
        run_op(32'h7FFFFFFF, 1'b1);

        // Second edge while busy is dropped: exactly one done
        launch_only(deg(45), 1'b1);
        push_exp(deg(45), 1'b1, cyc);
        repeat (5) @(posedge aclk);
        #1 start = 1'b0;
        @(posedge aclk); #1 start = 1'b1;
        repeat (2) @(posedge aclk);
        #1 start = 1'b0;
        wait_drain();
        repeat (25) @(posedge aclk);

        // Start held across completion must not relaunch
        launch_only(deg(-30), 1'b0);
        push_exp(deg(-30), 1'b0, cyc);
        wait_drain();
        repeat (25) @(posedge aclk);
        #1 start = 1'b0;

        // Soft abort during ITER: no done, busy and result cleared
        launch_only(deg(45), 1'b0);
        @(posedge aclk); #1 start = 1'b0;
        repeat (6) @(posedge aclk);
        #1 rst = 1'b1;
        @(negedge aclk);
        check("rst_busy_before", busy == 1'b1, int'(busy), 1);
        @(negedge aclk);
        check("rst_abort_busy", busy == 1'b0, int'(busy), 0);
        check("rst_abort_result", result_out == 32'h0, int'(result_out), 0);
        rst = 1'b0;
        repeat (30) @(posedge aclk);
        run_op(deg(30), 1'b0);

        // Hard reset mid-operation behaves the same way
        launch_only(deg(-60), 1'b1);
        @(posedge aclk); #1 start = 1'b0;
        repeat (8) @(posedge aclk);
        #1 aresetn = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("arst_abort_busy", busy == 1'b0, int'(busy), 0);
        check("arst_abort_result", result_out == 32'h0, int'(result_out), 0);
        aresetn = 1'b1;
        repeat (30) @(posedge aclk);
        run_op(deg(-60), 1'b1);

        // Random angles: mostly near one turn, some anywhere in range
        for (int n = 0; n < 40; n++) begin
            logic [31:0] th;
            if (n % 8 == 7) th = $urandom;
            else            th = 32'($urandom_range(0, 400 * 65536)) - deg(200);
            run_op(th, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cordic_sincos_core.md
Name: cordic_sincos_core

Overview:
- Iterative rotation-mode CORDIC engine that computes sine or cosine of a signed Q16.16 angle in degrees.
- Sits directly downstream of the AXI4-Lite CORDIC register controller and consumes its theta_deg, mode, start and rst outputs.
- Returns a Q16.16 result_out and a one-cycle done pulse, which the controller latches.
- Performs one micro-rotation per clock, with range reduction to [-90°, 90°] before iterating.

Parameters:
ITERATIONS, 16, number of micro-rotations (1..30)
DATA_W, 32, width of theta_deg and result_out
INT_FRAC, 30, fraction bits of the internal X/Y datapath (Q2.30)

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  synchronous, active-low reset
rst  in  1  synchronous active-high soft reset (abort) from controller flags
theta_deg  in  32  signed angle, Q16.16 degrees; sampled on start edge
mode  in  1  0 = sine, 1 = cosine; sampled on start edge
start  in  1  level from controller; rising edge launches an operation
result_out  out  32  signed Q16.16 result; held until next done
done  out  1  one-cycle pulse when result_out is updated
busy  out  1  high from accepted start until done

Behaviour:
- Reset (aresetn=0): state=IDLE; result_out=0, done=0, busy=0, start_q=0, and all internal registers cleared.
- Start edge detection:
  - start_q <= start every cycle, including during busy and rst.
  - Launch occurs when start && !start_q && state==IDLE && !rst.
  - Edges seen while busy are dropped and are not queued.
  - A start already high on the first cycle after reset counts as an edge.
- rst=1: same effect as aresetn, except start_q keeps tracking. This aborts any operation in the next cycle with no done pulse and leaves result_out=0.
- done is registered, high for exactly one cycle, and never asserted twice for one launch.
- FSM states IDLE -> REDUCE -> QUAD -> ITER -> FINISH -> IDLE:
  - IDLE: on launch, z <= theta_deg, mode_r <= mode, busy <= 1, go to REDUCE.
  - REDUCE: if z >= 180·2^16, z <= z - 360·2^16 and stay. Else if z < -180·2^16, z <= z + 360·2^16 and stay. Else go to QUAD. One adjustment per cycle; worst case is about 92 cycles for full-range input.
  - QUAD (z is now in [-180°, 180°)):
    - z > 90°: z <= z - 180°, neg <= 1.
    - z < -90°: z <= z + 180°, neg <= 1.
    - otherwise neg <= 0.
    - Then x <= K_INIT, y <= 0, i <= 0, go to ITER.
  - ITER, with d = (z >= 0) ? +1 : -1:
    - x <= x - d·(y >>> i), y <= y + d·(x >>> i), z <= z - d·ATAN_LUT[i].
    - All shifts are arithmetic.
    - At i == ITERATIONS-1 go to FINISH, else i <= i+1.
  - FINISH:
    - v = mode_r ? x : y; if neg, v = -v.
    - result_out <= (v + 2^13) >>> 14, i.e. round-half-up into Q16.16, sign-extended to 32 bits.
    - done <= 1, busy <= 0, go to IDLE.
- Latency: for theta in [-180°, 180°), done is high on the (ITERATIONS+4)th rising edge after the launch edge (20 for the default). Add one cycle per REDUCE adjustment.
- Arithmetic:
  - X/Y are 32-bit signed Q2.30 and cannot overflow because |x|,|y| ≤ 1.0 after gain compensation. No saturation is needed.
  - z is 32-bit signed Q16.16 degrees.
  - K_INIT = 0x26DD3B6A (0.6072529 · 2^30).
- Accuracy: |error| ≤ 4 LSB of Q16.16 for ITERATIONS=16.
- Boundary cases:
  - θ = +180° reduces to -180°, which gives sin = 0 and cos = -1.0 (0xFFFF0000 ±4).
  - θ = ±90° must not take the negation path.

Decomposition:
- Shared package/include cordic_defs holds:
  - state encodings
  - DEG_90, DEG_180, DEG_360 in Q16.16 (0x005A0000, 0x00B40000, 0x01680000)
  - K_INIT
  - ATAN_LUT contents, entry = round(atan(2^-i)·180/π·2^16): i0=2949120, i1=1740967, i2=919879, i3=466945, ...
- One sub-module, cordic_atan_rom: a combinational LUT indexed by i. It is shared with any future vectoring-mode core.

Test Plan:
- θ=0x001E0000 (30°), mode=0 -> result_out=0x00008000 ±4, done pulse exactly 20 cycles after the start edge, busy high in between.
- θ=0x003C0000 (60°), mode=1 -> 0x00008000 ±4; θ=0 mode=1 -> 0x00010000 ±4; θ=90° mode=0 -> 0x00010000 ±4.
- Quadrant folding:
  - θ=150° mode=0 -> 0x00008000 ±4.
  - θ=0xFF880000 (-120°) mode=1 -> 0xFFFF8000 ±4.
  - θ=180° mode=1 -> 0xFFFF0000 ±4.
- θ=390° mode=0 -> 0x00008000 ±4 with latency 21 cycles; θ=-32768° -> correct value, done arrives with no hang.
- Second start edge while busy -> ignored, one done only. Start held high across completion -> no relaunch.
- rst pulse during ITER -> busy=0 and result_out=0 next cycle, no done. A subsequent start edge -> normal 20-cycle result. aresetn mid-operation -> same.
